// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state type for the IOBUS UART transmitter.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  localparam int unsigned CTRL_IRQ_EN   = 0;
  localparam int unsigned CTRL_IRQ_PEND = 1;
  localparam int unsigned CTRL_OVF_CLR  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/iobus_byte_fifo.sv
// Byte-wide show-ahead FIFO with synchronous clear; a pop frees a slot for a same-cycle push.
module iobus_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS with TX FIFO and drain interrupt.
module iobus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR       = 32'h1100_0100,
  parameter logic [15:0]  DEFAULT_DIVISOR = 16'd868,
  parameter int unsigned  FIFO_DEPTH      = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        INTR
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q;
  logic [15:0]    baud_q, divisor_q, div_m1;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q, fifo_dout;
  logic           tx_q, intr_q, irq_en_q, irq_pend_q, ovf_q;
  logic           hit, wr_hit, push_req, ctrl_wr, pop, stop_done, irq_set, ovf_set;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    cnt_wide, status;
  logic [3:0]     cnt_sat;
  logic [1:0]     offset;
  logic           unused_bits;

  assign hit         = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign offset      = IOBUS_ADDR[3:2];
  assign wr_hit      = IOBUS_WR & hit;
  assign push_req    = wr_hit & (offset == REG_TXDATA);
  assign ctrl_wr     = wr_hit & (offset == REG_CTRL);
  assign pop         = (state_q == IDLE) & ~fifo_empty;
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

  // A programmed divisor of 0 behaves as 1 cycle per bit.
  assign div_m1    = (divisor_q == 16'd0) ? 16'd0 : divisor_q - 16'd1;
  assign stop_done = (state_q == STOP) && (baud_q == 16'd0);
  assign irq_set   = stop_done & fifo_empty & ~push_req;
  assign ovf_set   = push_req & fifo_full & ~pop;

  iobus_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .clr   (RESET),
    .push  (push_req),
    .pop   (pop),
    .din   (IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // TX is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= div_m1;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_q == 16'd0) begin
            baud_q  <= div_m1;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (baud_q == 16'd0) begin
            baud_q  <= div_m1;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_q == 16'd0) state_q <= IDLE;
          else                 baud_q  <= baud_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      divisor_q  <= DEFAULT_DIVISOR;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      if (wr_hit && offset == REG_DIVISOR) divisor_q <= IOBUS_OUT[15:0];
      if (ctrl_wr) irq_en_q <= IOBUS_OUT[CTRL_IRQ_EN];
      // Set wins over a same-cycle write-1-to-clear.
      if (irq_set)                               irq_pend_q <= 1'b1;
      else if (ctrl_wr && IOBUS_OUT[CTRL_IRQ_PEND]) irq_pend_q <= 1'b0;
      if (ovf_set)                               ovf_q <= 1'b1;
      else if (ctrl_wr && IOBUS_OUT[CTRL_OVF_CLR])  ovf_q <= 1'b0;
      intr_q <= irq_en_q & irq_pend_q;
    end
  end

  assign cnt_wide = 32'(fifo_count);
  assign cnt_sat  = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

  always_comb begin
    status                       = '0;
    status[STAT_BUSY]            = (state_q != IDLE);
    status[STAT_FULL]            = fifo_full;
    status[STAT_EMPTY]           = fifo_empty;
    status[STAT_OVF]             = ovf_q;
    status[STAT_CNT_LSB +: 4]    = cnt_sat;
  end

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      unique case (offset)
        REG_TXDATA:  IOBUS_IN = '0;
        REG_STATUS:  IOBUS_IN = status;
        REG_DIVISOR: IOBUS_IN = {16'd0, divisor_q};
        REG_CTRL: begin
          IOBUS_IN[CTRL_IRQ_EN]   = irq_en_q;
          IOBUS_IN[CTRL_IRQ_PEND] = irq_pend_q;
        end
        default:     IOBUS_IN = '0;
      endcase
    end
  end

  assign TX   = tx_q;
  assign INTR = intr_q;

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as the responder on the MCU's IOBUS.
- Decodes IOBUS_ADDR/IOBUS_OUT/IOBUS_WR driven by OTTER_MCU and returns register read data on IOBUS_IN.
- Buffers bytes in an internal FIFO and serialises them 8N1, LSB first, on TX.
- Drives INTR back to the MCU when the transmitter drains.

Parameters:
- BASE_ADDR, 32'h1100_0100, base of a 16-byte register window; bits [3:0] must be 0.
- DEFAULT_DIVISOR, 16'd868, reset value of DIVISOR (100 MHz / 115200 baud).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- IOBUS_ADDR  input  32  byte address from MCU.
- IOBUS_OUT  input  32  write data from MCU.
- IOBUS_WR  input  1  write strobe from MCU, one cycle per store.
- IOBUS_IN  output  32  read data to MCU; combinational.
- TX  output  1  serial line, idle high.
- INTR  output  1  level interrupt to MCU.

Behaviour:
- Decode: hit = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]); offset = IOBUS_ADDR[3:2]; [1:0] ignored. Writes take effect only when IOBUS_WR & hit.
- 0x0 TXDATA:
  - Write pushes IOBUS_OUT[7:0].
  - Reads 0.
- 0x4 STATUS (read-only; writes ignored):
  - bit0 busy (state != IDLE).
  - bit1 full.
  - bit2 empty.
  - bit3 overflow (sticky).
  - bits[7:4] count, saturating at 15.
  - Other bits 0.
- 0x8 DIVISOR:
  - RW, [15:0]; upper bits read 0.
  - Value 0 is treated as 1.
  - A write takes effect at the next bit-period start; the bit in flight is unaffected.
- 0xC CTRL:
  - bit0 irq_en: RW.
  - bit1 irq_pending: read; write 1 clears.
  - bit2 overflow: write 1 clears; reads as 0 here.
- IOBUS_IN is 0 when not hit. Reads have no side effects.
- Reset (synchronous) sets: TX=1, state IDLE, FIFO empty, DIVISOR=DEFAULT_DIVISOR, irq_en=0, irq_pending=0, overflow=0, INTR=0.
  - Reset mid-frame aborts the frame and flushes the FIFO; TX=1 after that edge.
- FIFO rules:
  - Push to a full FIFO drops the byte and sets overflow.
  - Simultaneous push and pop: both happen and count is unchanged. This includes the full case, because the pop frees a slot in the same cycle.
  - Pop occurs only in IDLE.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO is not empty, pop into shift register, load baud counter with DIVISOR-1, go to START. Otherwise TX=1.
  - START: TX=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for DIVISOR cycles per bit, shifting right. After bit 7, go to STOP.
  - STOP: TX=1 for DIVISOR cycles, then go to IDLE.
  - TX is registered. Frame length is exactly 10*DIVISOR cycles.
- Latency:
  - TXDATA write sampled at edge k with FIFO empty and IDLE: pop at edge k+1; TX low from edge k+2.
  - Back-to-back frames: 1 idle-high cycle between STOP end and the next START.
- Interrupt:
  - irq_pending sets on the edge where STOP completes and the FIFO is empty, with no push in the same cycle.
  - Set has priority over a simultaneous W1C.
  - INTR = irq_en & irq_pending, registered.
- Counters are unsigned 16-bit. The baud counter decrements to 0; reaching 0 marks the end of the bit.

Decomposition:
- Package uart_pkg:
  - Register offsets REG_TXDATA/REG_STATUS/REG_DIVISOR/REG_CTRL.
  - STATUS/CTRL bit-position constants.
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP}.
- Sub-module iobus_byte_fifo:
  - Parameterised depth, 8-bit wide.
  - Ports: push, pop, din, dout (head, show-ahead), full, empty, count.
  - Synchronous active-high clear.

Test Plan:
1. Reset; read 0x4 -> 0x0000_0004. Read 0x8 -> 868. TX=1, INTR=0.
2. Write DIVISOR=4, write TXDATA=0x55 -> TX low from the 2nd edge after the write, then 1,0,1,0,1,0,1,0, then stop 1, each level 4 cycles, 40 cycles total. STATUS busy=1 during the frame.
3. DIVISOR=2, irq_en=1; write 0xA5, 0x3C back-to-back -> two frames with 1 idle cycle between. INTR rises one cycle after the second STOP ends. Writing CTRL=0x3 clears INTR next cycle and keeps irq_en=1.
4. DIVISOR=100; write 10 bytes 0x00..0x09 in consecutive cycles -> first byte popped, next 8 fill FIFO (full=1), 10th dropped, overflow=1. TX shows 0x00..0x08 only. CTRL write 0x4 clears overflow.
5. Assert RESET mid-DATA of 0xFF with 3 bytes queued -> TX=1 the cycle after reset. STATUS=0x4. No further frames.
6. Write TXDATA at IOBUS_ADDR=BASE_ADDR+0x10 (miss) -> no frame. IOBUS_IN=0 for the miss; a DIVISOR=0 frame runs at 1 cycle/bit.
